// File: rtl/capture_readout_pkg.sv
// Shared definitions for the sample-RAM readout path and the acquisition block.
package capture_readout_pkg;

    localparam int unsigned RAM_WIDTH    = 10;
    localparam int unsigned SAMPLE_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAITRDY,
        STREAM,
        DRAIN
    } rd_state_t;

endpackage

// File: rtl/capture_readout_fifo.sv
// Small synchronous FIFO for streamed sample bytes.
// The head is forced to zero while empty.
module readout_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rdata,
    output logic                         valid,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_push = push && (count_q != CW'(DEPTH));
    assign do_pop  = pop && (count_q != '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

    assign valid = (count_q != '0);
    assign rdata = valid ? mem[rd_ptr] : '0;
    assign count = count_q;

endmodule

// File: rtl/capture_readout.sv
// Readout sequencer: walks the sample RAM from the first pre-trigger address
// and streams bytes over valid/ready, with credit-based read issue.
module capture_readout
    import capture_readout_pkg::*;
#(
    parameter int unsigned ram_width  = RAM_WIDTH,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic                    data_ready,
    input  logic [ram_width-1:0]    wraddress_triggerpoint,
    input  logic [ram_width-1:0]    triggerpoint,
    input  logic [ram_width:0]      nsamples,
    output logic                    rden,
    output logic [ram_width-1:0]    rdaddress,
    input  logic [SAMPLE_WIDTH-1:0] q,
    output logic [SAMPLE_WIDTH-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    aborted
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned NS_W  = ram_width + 1;
    localparam logic [NS_W-1:0] FULL_COUNT = {1'b1, {ram_width{1'b0}}};

    rd_state_t             state_q;
    rd_state_t             state_d;
    logic [ram_width-1:0]  addr_q;
    logic [NS_W-1:0]       remaining_q;
    logic [NS_W-1:0]       clamped;
    logic [RD_LATENCY-1:0] flight_q;
    logic                  done_q;
    logic                  aborted_q;
    logic                  done_d;
    logic                  aborted_d;
    logic                  accept;
    logic                  issue;
    logic                  abort;
    logic                  credit;
    logic                  drain_empty;
    logic                  push;
    logic                  pop;
    logic [CNT_W-1:0]      fifo_count;
    int unsigned           inflight;

    assign clamped = (nsamples > FULL_COUNT) ? FULL_COUNT : nsamples;

    always_comb begin
        inflight = 0;
        for (int unsigned i = 0; i < RD_LATENCY; i++) begin
            if (flight_q[i]) inflight = inflight + 1;
        end
    end

    // Every issued read reserves a FIFO slot until its byte is popped.
    assign credit      = (32'(fifo_count) + inflight) < FIFO_DEPTH;
    assign pop         = out_valid & out_ready;
    assign drain_empty = (fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop);
    assign push        = flight_q[RD_LATENCY-1] & ~abort;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        issue     = 1'b0;
        abort     = 1'b0;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        case (state_q)
            IDLE: begin
                // a start coinciding with the previous done pulse is dropped
                if (start && !done_q) begin
                    accept = 1'b1;
                    if (clamped == '0) done_d  = 1'b1;
                    else               state_d = WAITRDY;
                end
            end
            WAITRDY: begin
                if (data_ready) state_d = STREAM;
            end
            STREAM: begin
                if (!data_ready) begin
                    abort = 1'b1;
                end else if (credit) begin
                    issue = 1'b1;
                    if (remaining_q == NS_W'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!data_ready) begin
                    abort = 1'b1;
                end else if (inflight == 0 && drain_empty) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d   = IDLE;
            done_d    = 1'b1;
            aborted_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_q      <= '0;
            remaining_q <= '0;
            flight_q    <= '0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            done_q    <= done_d;
            aborted_q <= aborted_d;
            if (accept) begin
                addr_q      <= wraddress_triggerpoint - triggerpoint;
                remaining_q <= clamped;
            end else if (issue) begin
                addr_q      <= addr_q + ram_width'(1);
                remaining_q <= remaining_q - NS_W'(1);
            end
            if (abort) begin
                flight_q <= '0;
            end else begin
                flight_q[0] <= issue;
                for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                    flight_q[i] <= flight_q[i-1];
                end
            end
        end
    end

    readout_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(SAMPLE_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .flush (abort),
        .push  (push),
        .wdata (q),
        .pop   (pop),
        .rdata (out_data),
        .valid (out_valid),
        .count (fifo_count)
    );

    assign rden      = issue;
    assign rdaddress = addr_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign aborted   = aborted_q;

endmodule

// File: tb/tb_capture_readout.sv
// Self-checking bench for capture_readout with a 2-cycle-latency RAM model.
module tb_capture_readout;

    localparam int AW    = 10;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic          data_ready;
    logic [AW-1:0] wraddress_triggerpoint;
    logic [AW-1:0] triggerpoint;
    logic [AW:0]   nsamples;
    logic          rden;
    logic [AW-1:0] rdaddress;
    logic [7:0]    q;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          done;
    logic          aborted;

    capture_readout #(
        .ram_width (AW),
        .RD_LATENCY(LAT),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk                   (clk),
        .rstn                  (rstn),
        .start                 (start),
        .data_ready            (data_ready),
        .wraddress_triggerpoint(wraddress_triggerpoint),
        .triggerpoint          (triggerpoint),
        .nsamples              (nsamples),
        .rden                  (rden),
        .rdaddress             (rdaddress),
        .q                     (q),
        .out_data              (out_data),
        .out_valid             (out_valid),
        .out_ready             (out_ready),
        .busy                  (busy),
        .done                  (done),
        .aborted               (aborted)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] byte_of(input int a);
        int v;
        v = a * 37 + (a / 256) * 91 + 11;
        return 8'(v);
    endfunction

    // RAM model: data appears LAT cycles after the read request.
    logic [7:0] p1;
    logic [7:0] p2;
    always @(posedge clk) begin
        p1 <= rden ? byte_of(int'(rdaddress)) : 8'hEE;
        p2 <= p1;
    end
    assign q = p2;

    int rd_addr_log[$];
    int rd_cyc_log[$];
    int hs_byte_log[$];
    int hs_cyc_log[$];
    int done_cyc_log[$];
    int done_ab_log[$];
    int cyc  = 0;
    int outst = 0;
    int viol = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rden) begin
            rd_addr_log.push_back(int'(rdaddress));
            rd_cyc_log.push_back(cyc);
        end
        if (out_valid && out_ready) begin
            hs_byte_log.push_back(int'(out_data));
            hs_cyc_log.push_back(cyc);
        end
        if (done) begin
            done_cyc_log.push_back(cyc);
            done_ab_log.push_back(int'(aborted));
        end
        if (!rstn || done) begin
            outst <= 0;
        end else begin
            if (outst + int'(rden) > DEPTH) viol <= viol + 1;
            outst <= outst + int'(rden) - int'(out_valid && out_ready);
        end
    end

    int checks = 0;
    int errors = 0;
    int rd0, hs0, dn0;
    bit rdy_random = 1'b0;

    typedef struct {
        logic [AW-1:0] wr;
        logic [AW-1:0] tp;
        logic [AW:0]   ns;
        int            first;
        int            count;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        if (rdy_random) out_ready = ($urandom_range(0, 9) < 3);
    endtask

    task automatic snap();
        rd0 = rd_addr_log.size();
        hs0 = hs_byte_log.size();
        dn0 = done_cyc_log.size();
    endtask

    task automatic wait_done(input int max_cyc, input string tag);
        int n = 0;
        while (!done && n < max_cyc) begin
            cycle();
            n++;
        end
        check({tag, "_timeout"}, int'(done), 1);
        @(negedge clk);
        #1;
    endtask

    task automatic run_readout(input logic [AW-1:0] wr, input logic [AW-1:0] tp,
                               input logic [AW:0] ns, input int max_cyc, input string tag);
        cycle();
        snap();
        wraddress_triggerpoint = wr;
        triggerpoint           = tp;
        nsamples               = ns;
        start                  = 1'b1;
        cycle();
        start = 1'b0;
        wait_done(max_cyc, tag);
    endtask

    task automatic verify_run(input string tag, input int first, input int count, input bit timed);
        int nrd = rd_addr_log.size() - rd0;
        int nhs = hs_byte_log.size() - hs0;
        int dmis = 0;
        int amis = 0;
        check({tag, "_nreads"}, nrd, count);
        check({tag, "_nbytes"}, nhs, count);
        for (int k = 0; k < nhs; k++)
            if (hs_byte_log[hs0+k] != int'(byte_of((first + k) % 1024))) dmis++;
        for (int k = 0; k < nrd; k++)
            if (rd_addr_log[rd0+k] != (first + k) % 1024) amis++;
        check({tag, "_data_mismatches"}, dmis, 0);
        check({tag, "_addr_mismatches"}, amis, 0);
        check({tag, "_done_pulses"}, done_cyc_log.size() - dn0, 1);
        if (done_cyc_log.size() > dn0) check({tag, "_aborted"}, done_ab_log[dn0], 0);
        if (timed && count > 0 && nhs == count && nrd > 0) begin
            check({tag, "_first_latency"}, hs_cyc_log[hs0] - rd_cyc_log[rd0], LAT + 1);
            check({tag, "_throughput"}, hs_cyc_log[hs0+nhs-1] - hs_cyc_log[hs0], count - 1);
            if (done_cyc_log.size() > dn0)
                check({tag, "_done_gap"}, done_cyc_log[dn0] - hs_cyc_log[hs0+nhs-1], 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int nacc;
        int mis;

        vecs[0] = '{wr: 10'd5,    tp: 10'd10,   ns: 11'd8,    first: 1019, count: 8};
        vecs[1] = '{wr: 10'd100,  tp: 10'd0,    ns: 11'd1,    first: 100,  count: 1};
        vecs[2] = '{wr: 10'd0,    tp: 10'd0,    ns: 11'd0,    first: 0,    count: 0};
        vecs[3] = '{wr: 10'd512,  tp: 10'd12,   ns: 11'd2000, first: 500,  count: 1024};
        vecs[4] = '{wr: 10'd1023, tp: 10'd1023, ns: 11'd1024, first: 0,    count: 1024};
        vecs[5] = '{wr: 10'd20,   tp: 10'd30,   ns: 11'd1025, first: 1014, count: 1024};
        vecs[6] = '{wr: 10'd3,    tp: 10'd7,    ns: 11'd3,    first: 1020, count: 3};

        rstn = 1'b0;
        start = 1'b0;
        data_ready = 1'b1;
        out_ready = 1'b1;
        wraddress_triggerpoint = '0;
        triggerpoint = '0;
        nsamples = '0;
        repeat (3) cycle();
        check("reset_rden", int'(rden), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_done", int'(done), 0);
        rstn = 1'b1;
        cycle();

        for (int i = 0; i < 7; i++) begin
            run_readout(vecs[i].wr, vecs[i].tp, vecs[i].ns, 3000, $sformatf("v%0d", i));
            verify_run($sformatf("v%0d", i), vecs[i].first, vecs[i].count, 1'b1);
        end

        rdy_random = 1'b1;
        run_readout(10'd700, 10'd36, 11'd64, 3000, "bp");
        rdy_random = 1'b0;
        out_ready = 1'b1;
        verify_run("bp", 664, 64, 1'b0);

        // Wait for data_ready, with a second start ignored while busy.
        cycle();
        snap();
        data_ready = 1'b0;
        wraddress_triggerpoint = 10'd300;
        triggerpoint = 10'd4;
        nsamples = 11'd16;
        start = 1'b1;
        check("wg_busy_before", int'(busy), 0);
        cycle();
        start = 1'b0;
        check("wg_busy_rise", int'(busy), 1);
        wraddress_triggerpoint = 10'd0;
        nsamples = 11'd5;
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (18) cycle();
        check("wg_no_rden_while_waiting", rd_addr_log.size() - rd0, 0);
        check("wg_busy_held", int'(busy), 1);
        data_ready = 1'b1;
        wait_done(500, "wg");
        verify_run("wg", 296, 16, 1'b1);

        // Start in the same cycle as done is ignored.
        wraddress_triggerpoint = 10'd40;
        nsamples = 11'd4;
        start = 1'b1;
        cycle();
        start = 1'b0;
        check("start_on_done_busy", int'(busy), 0);
        cycle();
        check("start_on_done_no_done", int'(done), 0);

        // Abort after 10 accepted bytes.
        cycle();
        snap();
        wraddress_triggerpoint = 10'd200;
        triggerpoint = 10'd0;
        nsamples = 11'd100;
        start = 1'b1;
        cycle();
        start = 1'b0;
        n = 0;
        while (hs_byte_log.size() - hs0 < 10 && n < 500) begin
            cycle();
            n++;
        end
        check("ab_reached_10", int'(hs_byte_log.size() - hs0 >= 10), 1);
        data_ready = 1'b0;
        cycle();
        check("ab_out_valid_dropped", int'(out_valid), 0);
        check("ab_done", int'(done), 1);
        check("ab_aborted", int'(aborted), 1);
        cycle();
        check("ab_busy_clear", int'(busy), 0);
        check("ab_done_single", int'(done), 0);
        nacc = hs_byte_log.size() - hs0;
        check("ab_accepted_10_or_11", int'(nacc == 10 || nacc == 11), 1);
        mis = 0;
        for (int k = 0; k < nacc; k++)
            if (hs_byte_log[hs0+k] != int'(byte_of(200 + k))) mis++;
        check("ab_prefix_data", mis, 0);
        data_ready = 1'b1;

        // Asynchronous reset mid-stream.
        cycle();
        snap();
        wraddress_triggerpoint = 10'd50;
        nsamples = 11'd100;
        start = 1'b1;
        cycle();
        start = 1'b0;
        n = 0;
        while (hs_byte_log.size() - hs0 < 5 && n < 500) begin
            cycle();
            n++;
        end
        check("rst_mid_busy", int'(busy), 1);
        rstn = 1'b0;
        #1;
        check("rst_async_rden", int'(rden), 0);
        check("rst_async_rdaddress", int'(rdaddress), 0);
        check("rst_async_out_valid", int'(out_valid), 0);
        check("rst_async_out_data", int'(out_data), 0);
        check("rst_async_busy", int'(busy), 0);
        check("rst_async_done", int'(done), 0);
        check("rst_async_aborted", int'(aborted), 0);
        repeat (3) cycle();
        rstn = 1'b1;
        cycle();
        check("rst_no_done_pulse", done_cyc_log.size() - dn0, 0);
        run_readout(10'd10, 10'd20, 11'd30, 500, "post_rst");
        verify_run("post_rst", 1014, 30, 1'b1);

        check("outstanding_limit_violations", viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/capture_readout.md
# capture_readout

Readout sequencer for the oscilloscope sample RAM, paired with the acquisition block that writes it. When a readout is requested and the capture is marked ready, the block computes the first pre-trigger address from the recorded trigger write address, reads the requested number of samples in order with address wrap-around, and streams them as bytes over a valid/ready interface. The downstream consumer is the host serial/USB transmitter.

## Interface

Parameters:
- ram_width, 10: sample RAM address width; the RAM depth is 2^ram_width.
- RD_LATENCY, 2: cycles from `rden`/`rdaddress` to valid `q` (1..3).
- FIFO_DEPTH, 4: output buffer depth; must be at least RD_LATENCY+1.

Ports:
- clk  in  1  single clock (the sample-RAM read clock).
- rstn  in  1  asynchronous active-low reset.
- start  in  1  readout request pulse; ignored while `busy`.
- data_ready  in  1  capture complete; level from the acquisition block.
- wraddress_triggerpoint  in  ram_width  write address latched at trigger.
- triggerpoint  in  ram_width  number of pre-trigger samples.
- nsamples  in  ram_width+1  samples to read; values above 2^ram_width are clamped.
- rden  out  1  RAM read enable.
- rdaddress  out  ram_width  RAM read address.
- q  in  8  RAM read data.
- out_data  out  8  streamed sample.
- out_valid  out  1  `out_data` is valid.
- out_ready  in  1  consumer accepts when high with `out_valid`.
- busy  out  1  readout in progress.
- done  out  1  one-cycle pulse at the end of a readout.
- aborted  out  1  qualifies `done`: readout was cut short.

## Operation

- States: IDLE, WAITRDY, STREAM, DRAIN.
- IDLE:
  - On `start`, latch `base = wraddress_triggerpoint - triggerpoint` (mod 2^ram_width) and `remaining = min(nsamples, 2^ram_width)`.
  - Go to WAITRDY and set `busy`.
  - If the clamped count is 0, go straight back to IDLE and pulse `done` with `aborted=0`. No reads are issued.
- WAITRDY: when `data_ready`=1, go to STREAM. Read addresses start at `base`.
- STREAM:
  - Assert `rden` with `rdaddress = base + k` (mod 2^ram_width) for k = 0..remaining-1, one read per cycle.
  - A read is issued only when `fifo_count + inflight < FIFO_DEPTH`, so a returning read can never overflow the FIFO.
  - Each read's `q` is captured into the FIFO RD_LATENCY cycles after it was issued.
  - After the last read is issued, go to DRAIN.
- DRAIN: when inflight=0 and the FIFO is empty, pulse `done` (`aborted=0`), clear `busy`, go to IDLE.
- Abort: if `data_ready` falls in STREAM or DRAIN (a new capture has started):
  - Stop issuing reads, discard in-flight data, flush the FIFO, and drop `out_valid` the next cycle.
  - Pulse `done` with `aborted=1` and return to IDLE.
- Output: `out_data`/`out_valid` are driven from the FIFO head. An entry pops when `out_valid & out_ready`. Bytes leave in strict address order with no duplicates and no gaps.
- `start` asserted in the same cycle as a `done` pulse is ignored.

## Timing

- Reset values: `rden`=0, `rdaddress`=0, `out_valid`=0, `out_data`=0, `busy`=0, `done`=0, `aborted`=0, FIFO empty, inflight=0, state IDLE.
- Reset mid-readout: state is lost immediately and no `done` pulse is generated.
- `busy` rises the cycle after an accepted `start`.
- First `rden` comes at the earliest one cycle after STREAM is entered.
- With `out_ready` held at 1, first `out_valid` comes RD_LATENCY+1 cycles after the first `rden`. After that, throughput is one byte per cycle.
- `done` is registered and comes one cycle after the last byte handshake.
- Address arithmetic is ram_width bits and wraps silently: address 2^ram_width-1 is followed by 0.
- `remaining` is ram_width+1 bits and counts down once per issued read.

## Structure

- Shared package holds:
  - the state enum (IDLE, WAITRDY, STREAM, DRAIN);
  - the `ram_width` default of 10, which the acquisition block must use too;
  - the sample width constant 8.
- Sub-module `readout_fifo`: synchronous FIFO, parameterised depth and width, with count output and flush input.
- The top level contains the FSM, the address counter, and the in-flight shift register of depth RD_LATENCY.

## Test plan

- Wrap: `wraddress_triggerpoint`=5, `triggerpoint`=10, `nsamples`=8, `data_ready`=1, `out_ready`=1 → reads at addresses 1019..1023, 0, 1, 2. The 8 bytes match the RAM model and `done` pulses once with `aborted`=0.
- Backpressure: `nsamples`=64, `out_ready` random at 30% duty → all 64 bytes in order, FIFO never exceeds 4 entries, no read is issued while `fifo_count+inflight`=4.
- Wait then go: `start` with `data_ready`=0 for 20 cycles → no `rden` during that time. After `data_ready` rises, streaming begins.
- Abort: drop `data_ready` after 10 of 100 bytes are accepted → `out_valid` is 0 the next cycle, then `done`=1 with `aborted`=1, then `busy`=0.
- Edge counts:
  - `nsamples`=0 → `done` with no `rden`.
  - `nsamples`=2000 → exactly 1024 bytes.
  - `start` while `busy` → ignored.
- Reset: assert `rstn`=0 mid-STREAM → all outputs are at their reset values asynchronously. A subsequent `start` runs a clean readout.
